// File: rtl/sound_cmd_fifo_if.sv
// Main-CPU to sound-CPU command channel bus: write strobe/data in, decoded read port,
// IRQ and status flags out.
interface sound_cmd_fifo_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          wr_n;
  logic [DW-1:0] din;
  logic          rd_cs_n;
  logic          rd_addr;
  logic          rd_done;
  logic [DW-1:0] dout;
  logic          irq_n;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;

  modport master (
    output wr_n, din, rd_cs_n, rd_addr, rd_done,
    input  dout, irq_n, count, full, empty, overflow
  );

  modport slave (
    input  wr_n, din, rd_cs_n, rd_addr, rd_done,
    output dout, irq_n, count, full, empty, overflow
  );
endinterface

// File: rtl/sound_cmd_fifo.sv
// Sound command FIFO: queues main-CPU writes, pops on sound-CPU data reads, drives IRQ
// and a {overflow, full, empty, count} status word. DEPTH=1/OVERWRITE=1/IRQ_MODE=1 acts as the old latch.
module sound_cmd_fifo #(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int OVERWRITE = 0,
  parameter int IRQ_MODE  = 0
) (
  input  logic             clk,
  input  logic             RSTn,
  sound_cmd_fifo_if.slave  bus
);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEMN = 1 << PW;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (DEPTH == 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (DEPTH == 1) ? '0 : p - 1'b1;
  endfunction

  logic [DW-1:0] mem [MEMN];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          ovf_q, ovf_d, pend_q, pend_d, irq_n_q, irq_n_d;
  logic [DW-1:0] dout_q, dout_d, last_q, last_d, hold_q, hold_d;
  logic          wrn_q;

  logic          push, pop, rd_sel, push_acc, ovf_evt, mem_we;
  logic [PW-1:0] mem_idx;
  logic [DW-1:0] head, status;

  assign head     = mem[rd_ptr_q];
  assign push     = !wrn_q && bus.wr_n;
  assign rd_sel   = bus.rd_done && !bus.rd_cs_n;
  assign pop      = rd_sel && !bus.rd_addr && !empty_q;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push_acc = push && (!full_q || pop);
  assign ovf_evt  = push && full_q && !pop;

  always_comb begin
    status          = '0;
    status[CW-1:0]  = count_q;
    status[DW-3]    = empty_q;
    status[DW-2]    = full_q;
    status[DW-1]    = ovf_q;
  end

  always_comb begin
    wr_ptr_d = push_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop      ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push_acc) - CW'(pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    last_d   = pop ? head : last_q;
    hold_d   = bus.wr_n ? hold_q : bus.din;

    mem_we   = push_acc || (ovf_evt && (OVERWRITE != 0));
    mem_idx  = push_acc ? wr_ptr_q : ptr_dec(wr_ptr_q);

    if (ovf_evt)                     ovf_d = 1'b1;
    else if (rd_sel && bus.rd_addr)  ovf_d = 1'b0;
    else                             ovf_d = ovf_q;

    if (push)                        pend_d = 1'b1;
    else if (rd_sel && !bus.rd_addr) pend_d = 1'b0;
    else                             pend_d = pend_q;

    irq_n_d = (IRQ_MODE != 0) ? !pend_d : empty_d;

    // Empty data reads re-return the last popped command, as the old latch did.
    if (bus.rd_addr)  dout_d = status;
    else if (empty_q) dout_d = last_q;
    else              dout_d = head;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= hold_q;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
      irq_n_q  <= 1'b1;
      dout_q   <= '1;
      last_q   <= '1;
      hold_q   <= '0;
      wrn_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
      irq_n_q  <= irq_n_d;
      dout_q   <= dout_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      wrn_q    <= bus.wr_n;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.irq_n    = irq_n_q;
  assign bus.count    = count_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_sound_cmd_fifo.sv
// Drives three FIFO configurations with shared stimulus and compares every cycle
// against a queue-level model of the command channel.
module tb_sound_cmd_fifo;
  logic       clk = 1'b0;
  logic       RSTn;
  logic       wr_n, rd_cs_n, rd_addr, rd_done;
  logic [7:0] din;

  always #5 clk = ~clk;

  sound_cmd_fifo_if #(.DW(8), .DEPTH(4)) if0 ();
  sound_cmd_fifo_if #(.DW(8), .DEPTH(4)) if1 ();
  sound_cmd_fifo_if #(.DW(8), .DEPTH(1)) if2 ();

  assign if0.wr_n = wr_n;  assign if0.din = din;  assign if0.rd_cs_n = rd_cs_n;
  assign if0.rd_addr = rd_addr;  assign if0.rd_done = rd_done;
  assign if1.wr_n = wr_n;  assign if1.din = din;  assign if1.rd_cs_n = rd_cs_n;
  assign if1.rd_addr = rd_addr;  assign if1.rd_done = rd_done;
  assign if2.wr_n = wr_n;  assign if2.din = din;  assign if2.rd_cs_n = rd_cs_n;
  assign if2.rd_addr = rd_addr;  assign if2.rd_done = rd_done;

  sound_cmd_fifo #(.DW(8), .DEPTH(4), .OVERWRITE(0), .IRQ_MODE(0)) u0 (.clk(clk), .RSTn(RSTn), .bus(if0));
  sound_cmd_fifo #(.DW(8), .DEPTH(4), .OVERWRITE(1), .IRQ_MODE(0)) u1 (.clk(clk), .RSTn(RSTn), .bus(if1));
  sound_cmd_fifo #(.DW(8), .DEPTH(1), .OVERWRITE(1), .IRQ_MODE(1)) u2 (.clk(clk), .RSTn(RSTn), .bus(if2));

  logic [7:0] o_dout [3];
  logic [2:0] o_cnt  [3];
  logic       o_irq [3], o_full [3], o_empty [3], o_ovf [3];

  assign o_dout[0] = if0.dout;  assign o_cnt[0] = if0.count;  assign o_irq[0] = if0.irq_n;
  assign o_full[0] = if0.full;  assign o_empty[0] = if0.empty; assign o_ovf[0] = if0.overflow;
  assign o_dout[1] = if1.dout;  assign o_cnt[1] = if1.count;  assign o_irq[1] = if1.irq_n;
  assign o_full[1] = if1.full;  assign o_empty[1] = if1.empty; assign o_ovf[1] = if1.overflow;
  assign o_dout[2] = if2.dout;  assign o_cnt[2] = {2'b00, if2.count}; assign o_irq[2] = if2.irq_n;
  assign o_full[2] = if2.full;  assign o_empty[2] = if2.empty; assign o_ovf[2] = if2.overflow;

  // Reference model: each instance is an ordered list of queued commands.
  int         m_dep [3] = '{4, 4, 1};
  int         m_ow  [3] = '{0, 1, 1};
  int         m_im  [3] = '{0, 0, 1};
  logic [7:0] mb [3][16];
  int         mn [3];
  logic       mo [3], mp [3], mw [3];
  logic [7:0] ml [3], md [3], mh [3];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mstat(input int k);
    logic [7:0] s;
    s      = '0;
    s[7]   = mo[k];
    s[6]   = (mn[k] == m_dep[k]);
    s[5]   = (mn[k] == 0);
    s[2:0] = mn[k][2:0];
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mn[k] = 0; mo[k] = 1'b0; mp[k] = 1'b0; mw[k] = 1'b1;
      ml[k] = 8'hFF; md[k] = 8'hFF; mh[k] = 8'h00;
    end
  endtask

  task automatic model_update();
    logic psh, sel, pp, ovfe;
    for (int k = 0; k < 3; k++) begin
      psh  = !mw[k] && wr_n;
      sel  = rd_done && !rd_cs_n;
      pp   = sel && !rd_addr && (mn[k] != 0);
      ovfe = 1'b0;
      md[k] = rd_addr ? mstat(k) : ((mn[k] != 0) ? mb[k][0] : ml[k]);
      if (pp) begin
        ml[k] = mb[k][0];
        for (int i = 0; i < 15; i++) mb[k][i] = mb[k][i+1];
        mn[k]--;
      end
      if (psh) begin
        if (mn[k] < m_dep[k]) begin
          mb[k][mn[k]] = mh[k];
          mn[k]++;
        end else begin
          ovfe = 1'b1;
          if (m_ow[k] != 0) mb[k][mn[k]-1] = mh[k];
        end
      end
      if (ovfe)                 mo[k] = 1'b1;
      else if (sel && rd_addr)  mo[k] = 1'b0;
      if (psh)                  mp[k] = 1'b1;
      else if (sel && !rd_addr) mp[k] = 1'b0;
      if (!wr_n) mh[k] = din;
      mw[k] = wr_n;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.u%0d.dout", tag, k), o_dout[k], md[k]);
      chk($sformatf("%s.u%0d.count", tag, k), o_cnt[k], mn[k]);
      chk($sformatf("%s.u%0d.full", tag, k), o_full[k], mn[k] == m_dep[k]);
      chk($sformatf("%s.u%0d.empty", tag, k), o_empty[k], mn[k] == 0);
      chk($sformatf("%s.u%0d.ovf", tag, k), o_ovf[k], mo[k]);
      chk($sformatf("%s.u%0d.irq_n", tag, k), o_irq[k],
          (m_im[k] != 0) ? !mp[k] : (mn[k] == 0));
    end
  endtask

  task automatic step(input string tag);
    if (RSTn) model_update();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic push(input logic [7:0] v);
    wr_n = 1'b0; din = v;
    step("wr");
    wr_n = 1'b1; din = 8'($urandom);
    step("push");
  endtask

  task automatic rd(input logic a);
    rd_cs_n = 1'b0; rd_addr = a; rd_done = 1'b1;
    step("rd");
    rd_cs_n = 1'b1; rd_addr = 1'b0; rd_done = 1'b0;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] e0 [4];
    logic [7:0] e1 [4];
    wr_n = 1'b1; din = 8'h00; rd_cs_n = 1'b1; rd_addr = 1'b0; rd_done = 1'b0;
    RSTn = 1'b1;
    #2;
    do_reset();
    chk("reset_dout", o_dout[0], 8'hFF);
    step("rst_hold");
    step("rst_hold");
    RSTn = 1'b1;
    step("idle");

    // In-order delivery, then empty re-read of the last command
    push(8'h8A); push(8'h09); push(8'h0F);
    chk("tp1_count", o_cnt[0], 3);
    chk("tp1_irq", o_irq[0], 0);
    rd(1'b0); chk("tp1_pop0", o_dout[0], 8'h8A);
    rd(1'b0); chk("tp1_pop1", o_dout[0], 8'h09);
    rd(1'b0); chk("tp1_pop2", o_dout[0], 8'h0F);
    chk("tp1_empty", o_empty[0], 1);
    chk("tp1_irq_off", o_irq[0], 1);
    rd(1'b0); chk("tp1_reread", o_dout[0], 8'h0F);

    // Overflow: drop (u0) vs overwrite newest (u1)
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("tp2_full", o_full[0], 1);
    chk("tp2_ovf", o_ovf[0], 1);
    rd(1'b1); chk("tp2_stat0", o_dout[0], 8'hC4); chk("tp2_stat1", o_dout[1], 8'hC4);
    rd(1'b1); chk("tp2_stat_clr", o_dout[0], 8'h44);
    chk("tp2_ovf_clr", o_ovf[0], 0);
    e0 = '{8'h01, 8'h02, 8'h03, 8'h04};
    e1 = '{8'h01, 8'h02, 8'h03, 8'h05};
    for (int i = 0; i < 4; i++) begin
      rd(1'b0);
      chk($sformatf("tp2_drop%0d", i), o_dout[0], e0[i]);
      chk($sformatf("tp2_ovw%0d", i), o_dout[1], e1[i]);
    end

    // Push and pop in the same clock on a full FIFO
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wr_n = 1'b0; din = 8'h55;
    step("pp_wr");
    wr_n = 1'b1; rd_cs_n = 1'b0; rd_addr = 1'b0; rd_done = 1'b1;
    step("pp");
    rd_cs_n = 1'b1; rd_done = 1'b0;
    chk("tp4_count", o_cnt[0], 4);
    chk("tp4_ovf", o_ovf[0], 0);
    chk("tp4_head", o_dout[0], 8'h11);
    e0 = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) begin
      rd(1'b0);
      chk($sformatf("tp4_pop%0d", i), o_dout[0], e0[i]);
    end

    // Legacy latch configuration (u2)
    push(8'hFD); push(8'h01);
    chk("tp5_irq_on", o_irq[2], 0);
    rd(1'b0); chk("tp5_data", o_dout[2], 8'h01); chk("tp5_irq_off", o_irq[2], 1);
    rd(1'b0); chk("tp5_reread", o_dout[2], 8'h01);
    push(8'hA0); push(8'hA1);

    // Asynchronous reset with entries queued
    chk("tp6_pre", o_cnt[0], 2);
    do_reset();
    chk("tp6_count", o_cnt[0], 0);
    chk("tp6_irq", o_irq[0], 1);
    chk("tp6_dout", o_dout[0], 8'hFF);
    step("rst_hold");
    RSTn = 1'b1;
    push(8'h5A);
    rd(1'b0); chk("tp6_after", o_dout[0], 8'h5A);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      wr_n    = ($urandom_range(0, 2) != 0);
      din     = 8'($urandom);
      rd_cs_n = ($urandom_range(0, 1) != 0);
      rd_addr = ($urandom_range(0, 3) == 0);
      rd_done = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 150) == 0) begin
        do_reset();
        step("rnd_rst");
        RSTn = 1'b1;
      end
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sound_cmd_fifo.md
Name: sound_cmd_fifo

Overview:
- Parametrised main-CPU-to-sound-CPU command channel that replaces the single-byte sound latch and its IRQ flip-flop.
- Commands written by the main CPU are queued in a DEPTH-entry FIFO, and the sound CPU pops them in order through a decoded read port.
- An IRQ is raised toward the sound CPU (level or one-shot mode), and a status word (count, full, empty, sticky overflow) is readable.
- DEPTH=1 with OVERWRITE=1 and IRQ_MODE=1 reproduces the legacy latch behaviour.

Parameters:
- DW, 8, command/data width; must satisfy DW >= $clog2(DEPTH+1)+3.
- DEPTH, 4, FIFO entries; power of two, 1..16.
- OVERWRITE, 0, full-FIFO policy: 0 = drop the new command, 1 = replace the newest entry.
- IRQ_MODE, 0, IRQ source: 0 = level while non-empty, 1 = pending flag set per push and cleared by a data read.

Ports:
- clk  in  1  master clock
- RSTn  in  1  asynchronous active-low reset
- wr_n  in  1  main-CPU write strobe (active low); the command is pushed on its rising edge
- din  in  DW  main-CPU data bus
- rd_cs_n  in  1  sound-CPU decoded chip select (active low)
- rd_addr  in  1  0 = data register, 1 = status register
- rd_done  in  1  single-clk pulse marking the end of a sound-CPU read cycle (E-fall enable)
- dout  out  DW  registered read data
- irq_n  out  1  sound-CPU IRQ (active low)
- count  out  $clog2(DEPTH+1)  number of queued entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky overflow flag

Behaviour:
- Reset (async, RSTn low) sets:
  - read/write pointers and count to 0;
  - empty=1, full=0, overflow=0, irq_n=1;
  - dout and last_val to all ones;
  - the internal wr_n history register to 1 and the holding register to 0.
- Memory contents are not reset. Release is synchronous to clk.
- Write capture:
  - hold_reg <= din on every clk with wr_n==0.
  - push = (wr_n_d==0 && wr_n==1), a one-clk event.
  - The pushed value is hold_reg, so din need not be held after the strobe deasserts.
- Pop: pop = rd_done && !rd_cs_n && !rd_addr && !empty, where empty is the pre-cycle value. Pop advances rd_ptr and copies the popped entry into last_val.
- Push, not full: mem[wr_ptr] <= hold_reg, wr_ptr++ (wrap modulo DEPTH), count++.
- Push with pop in the same cycle:
  - Both take effect and count is unchanged.
  - If full, the pop frees the slot, the push is accepted and no overflow is flagged.
  - If empty, no pop occurs (gated by empty), the push is accepted and count becomes 1.
- Push, full, no pop:
  - overflow <= 1.
  - OVERWRITE=0: the command is discarded and the pointers are unchanged.
  - OVERWRITE=1: mem[wr_ptr-1] <= hold_reg and the pointers are unchanged.
- Status word = {overflow, full, empty, zero pad, count} in the low bits, width DW.
- Overflow clear:
  - rd_done && !rd_cs_n && rd_addr clears overflow.
  - A simultaneous overflow event wins (overflow stays 1).
- Read data, registered with 1-clk latency every clk regardless of rd_cs_n:
  - rd_addr==1: dout <= status.
  - rd_addr==0 and not empty: dout <= mem[rd_ptr].
  - rd_addr==0 and empty: dout <= last_val (legacy re-read of the last command).
  - After a pop, the next clk's dout shows the new head.
- IRQ, registered:
  - IRQ_MODE=0: irq_n <= empty_next.
  - IRQ_MODE=1: pending <= 1 on push (including an overflow push); pending <= 0 on any rd_done && !rd_cs_n && !rd_addr, even when empty. Set wins on a collision. irq_n = ~pending.
- Flag timing: count, full and empty are registered and update the clk after push/pop.
- Pointer widths are $clog2(DEPTH), with a minimum of 1 bit. For DEPTH=1 the pointers stay 0.
- Reset asserted mid-transaction aborts it. A wr_n edge coinciding with RSTn release is ignored because the history register reset to 1.

Test Plan:
- Reset, then push 0x8A, 0x09, 0x0F: count=3, irq_n=0. Three data pops return 0x8A, 0x09, 0x0F in order, then empty=1, irq_n=1 (IRQ_MODE=0). A further data read returns 0x0F.
- DEPTH=4, OVERWRITE=0: push 5 commands 0x01..0x05. full=1, overflow=1, and pops yield 0x01..0x04. A status read returns 0xC4 before any pop; the next status read shows overflow=0.
- OVERWRITE=1, DEPTH=4: push 0x01..0x05. Pops yield 0x01, 0x02, 0x03, 0x05, and overflow=1.
- Full FIFO with push and pop in the same clk: count stays 4, overflow stays 0, and the new value appears last.
- DEPTH=1, OVERWRITE=1, IRQ_MODE=1: push 0xFD then 0x01. A data read returns 0x01 and drops irq_n to 1; re-reading returns 0x01.
- Assert RSTn low while count=2: count=0, irq_n=1, dout=0xFF immediately (async). A push after release works normally.
